// File: rtl/rom_uart_dump_pkg.sv
// rom_uart_dump_pkg: FSM encoding and framing constants shared with the download loader.
package rom_uart_dump_pkg;
  localparam int CNT_W          = 16;
  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_W         = 8 * BYTES_PER_WORD;
  localparam bit LITTLE_ENDIAN  = 1'b1;

  typedef enum logic [3:0] {
    IDLE, CNT_LSB, CNT_MSB, FETCH, WAIT_DATA, B0, B1, B2, B3, FINISH
  } state_e;

  function automatic logic [7:0] word_byte(input logic [WORD_W-1:0] w, input logic [1:0] i);
    return LITTLE_ENDIAN ? w[8*int'(i) +: 8] : w[8*(BYTES_PER_WORD-1-int'(i)) +: 8];
  endfunction
endpackage

// File: rtl/rom_uart_dump_uart_tx.sv
// uart_tx_byte: 8N1 byte serializer; tx_busy drops during the last stop-bit clock so the next byte can follow with one idle clock.
module uart_tx_byte #(
  parameter int BAUD_DIV = 16
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       tx
);
  localparam int BW = $clog2(BAUD_DIV + 1);
  logic [BW-1:0] baud_q;
  logic [3:0]    bit_q;
  logic [8:0]    sh_q;
  logic          busy_q, tx_q, tick;

  assign tick    = baud_q == BW'(BAUD_DIV - 1);
  assign tx_busy = busy_q && !(tick && bit_q == 4'd9);
  assign tx      = tx_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      baud_q <= '0;
      bit_q  <= '0;
      sh_q   <= '0;
      busy_q <= 1'b0;
      tx_q   <= 1'b1;
    end else if (!busy_q) begin
      if (tx_start) begin
        busy_q <= 1'b1;
        tx_q   <= 1'b0;
        sh_q   <= {1'b1, tx_data};
        baud_q <= '0;
        bit_q  <= '0;
      end
    end else if (!tick) begin
      baud_q <= baud_q + 1'b1;
    end else begin
      baud_q <= '0;
      bit_q  <= bit_q + 1'b1;
      tx_q   <= sh_q[0];
      sh_q   <= {1'b1, sh_q[8:1]};
      if (bit_q == 4'd9) busy_q <= 1'b0;
    end
  end
endmodule

// File: rtl/rom_uart_dump.sv
// rom_uart_dump: streams word_count ROM words over UART using the loader framing
// (16-bit little-endian count, then each word least-significant byte first).
module rom_uart_dump
  import rom_uart_dump_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 9600
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        start,
  input  logic [15:0] word_count,
  output logic        rom_rd_en,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  output logic        busy,
  output logic        done,
  output logic        uart_tx
);
  localparam int BAUD_DIV = CLK_FREQ / BAUD;

  state_e            state_q;
  logic [CNT_W-1:0]  count_q, idx_q, idx_d;
  logic [WORD_W-1:0] hold_q;
  logic [31:0]       addr_q;
  logic              armed_q, sent_q, busy_q, done_q, rd_en_q;
  logic              is_byte, tx_start, tx_busy, byte_done;
  logic [1:0]        byte_sel;
  logic [7:0]        tx_data;

  always_comb begin
    is_byte   = state_q inside {CNT_LSB, CNT_MSB, B0, B1, B2, B3};
    tx_start  = is_byte && !sent_q;
    byte_done = sent_q && !tx_busy;
    byte_sel  = state_q == B1 ? 2'd1 : state_q == B2 ? 2'd2 : state_q == B3 ? 2'd3 : 2'd0;
    tx_data   = state_q == CNT_LSB ? count_q[7:0] :
                state_q == CNT_MSB ? count_q[15:8] : word_byte(hold_q, byte_sel);
    idx_d     = state_q == B3 ? idx_q + 1'b1 : idx_q;
  end

  // armed_q keeps a start coincident with reset release from being taken
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      count_q <= '0;
      idx_q   <= '0;
      hold_q  <= '0;
      addr_q  <= '0;
      armed_q <= 1'b0;
      sent_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_en_q <= 1'b0;
    end else begin
      armed_q <= 1'b1;
      rd_en_q <= 1'b0;
      done_q  <= 1'b0;
      if (tx_start) sent_q <= 1'b1;
      case (state_q)
        IDLE: if (start && armed_q) begin
          count_q <= word_count;
          idx_q   <= '0;
          busy_q  <= 1'b1;
          state_q <= CNT_LSB;
        end
        CNT_LSB, B0, B1, B2: if (byte_done) begin
          sent_q  <= 1'b0;
          state_q <= state_q == CNT_LSB ? CNT_MSB : state_q == B0 ? B1 : state_q == B1 ? B2 : B3;
        end
        CNT_MSB, B3: if (byte_done) begin
          sent_q <= 1'b0;
          idx_q  <= idx_d;
          if (idx_d == count_q) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= FINISH;
          end else begin
            rd_en_q <= 1'b1;
            addr_q  <= {{(32-CNT_W){1'b0}}, idx_d};
            state_q <= FETCH;
          end
        end
        FETCH: state_q <= WAIT_DATA;
        WAIT_DATA: begin
          hold_q  <= rom_data;
          state_q <= B0;
        end
        FINISH: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rom_rd_en = rd_en_q;
  assign rom_addr  = addr_q;
  assign busy      = busy_q;
  assign done      = done_q;

  uart_tx_byte #(.BAUD_DIV(BAUD_DIV)) u_tx (
    .CLK     (CLK),
    .RESET   (RESET),
    .tx_start(tx_start),
    .tx_data (tx_data),
    .tx_busy (tx_busy),
    .tx      (uart_tx)
  );
endmodule

// File: doc/rom_uart_dump.md
# rom_uart_dump

Program readback engine for the single-cycle core. On a start pulse it reads `word_count` instruction words from the instruction ROM's readback port and transmits them over a dedicated UART TX line. It uses exactly the framing the download loader accepts:

- 16-bit word count, little-endian;
- then each 32-bit word, least-significant byte first.

A host can therefore verify a download by byte-comparing the dump with the file it sent.

## Interface
Parameters:
- `CLK_FREQ`, 50_000_000: system clock frequency in Hz.
- `BAUD`, 9600: line rate. `BAUD_DIV = CLK_FREQ/BAUD` (integer division) clocks per bit.

Ports:
- `CLK`  in  1  system clock, rising edge.
- `RESET`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `word_count`  in  16  number of words to dump; latched when `start` is accepted.
- `rom_rd_en`  out  1  one-cycle ROM read strobe.
- `rom_addr`  out  32  ROM word index (not a byte address).
- `rom_data`  in  32  ROM read data, valid the cycle after `rom_rd_en`.
- `busy`  out  1  high from the cycle after `start` is accepted until `done`.
- `done`  out  1  one-cycle pulse after the last stop bit.
- `uart_tx`  out  1  serial output, 8N1, idle high.

## Operation
- Reset values: `uart_tx`=1, `busy`=0, `done`=0, `rom_rd_en`=0, `rom_addr`=0. All internal counters are 0 and the FSM is in IDLE.
- FSM states: IDLE, CNT_LSB, CNT_MSB, FETCH, WAIT_DATA, B0, B1, B2, B3, FINISH.
- IDLE with `start`=1:
  - latch `word_count`;
  - clear the word index;
  - go to CNT_LSB.
- CNT_LSB, CNT_MSB: send `count[7:0]`, then `count[15:8]`.
  - Then go to FETCH, or to FINISH if count==0.
- FETCH: assert `rom_rd_en` for one cycle with `rom_addr` = word index, then go to WAIT_DATA.
- WAIT_DATA: capture `rom_data` into a 32-bit holding register, then go to B0.
- B0..B3: send `hold[7:0]`, `[15:8]`, `[23:16]`, `[31:24]` in that order.
  - After B3, increment the word index.
  - Go to FETCH, or to FINISH when the index equals the latched count.
- FINISH: pulse `done` for one cycle, drop `busy`, return to IDLE.
- Each byte state issues one request to the byte serializer and waits for it to report idle before advancing.
- `start` while `busy` is ignored. The latched count is unaffected by later `word_count` changes.
- Count 0xFFFF: 65535 words at indices 0..65534. The word index is 16 bits and `rom_addr` is zero-extended from it. No wrap occurs.
- RESET asserted mid-frame:
  - `uart_tx` goes high immediately (asynchronously);
  - the partial frame is abandoned;
  - no `done` pulse is produced;
  - after release the block is in IDLE.
- `start` asserted in the same cycle as RESET release is ignored. The first acceptable `start` is one cycle after release.

## Timing
- Bit period is `BAUD_DIV` clocks. Frame = start bit (0), 8 data bits LSB first, stop bit (1): `10*BAUD_DIV` clocks.
- `start` accepted at edge t:
  - `busy`=1 from cycle t+1;
  - `uart_tx` falls at cycle t+2.
- Inter-frame gap: at most 1 idle clock between a stop bit and the next start bit within a word. At most 3 clocks across a word boundary (FETCH + WAIT_DATA).
- Total dump time ≤ `(2+4N)*10*BAUD_DIV + 3N + 4` clocks.
- `done` is asserted the cycle after the final stop bit ends. `busy` falls in that same cycle.

## Structure
- Sub-module `uart_tx_byte`:
  - inputs: `CLK`, `RESET`, `tx_start`, `tx_data[7:0]`;
  - outputs: `tx_busy`, `tx`;
  - contents: baud counter, bit counter and shift register.
- Shared package holds the FSM state encoding and the loader/dump framing constants:
  - count width 16;
  - bytes per word 4;
  - little-endian byte order.
- The package is shared with the download loader so both ends stay consistent.

## Test plan
Bench parameters: `CLK_FREQ`=160, `BAUD`=10 (so `BAUD_DIV`=16). The ROM model returns `0xA0000000+index`.
- `word_count`=2, start → line bytes 02 00 00 00 00 A0 01 00 00 A0. `done` arrives exactly one cycle after the last stop bit. `rom_addr` sequence is 0, 1.
- `word_count`=0 → bytes 00 00 only, then `done`. `rom_rd_en` never asserted.
- Decode the bit-level waveform of byte 0x02 → low 16 clk, then bits 0,1,0,0,0,0,0,0 (16 clk each), then high 16 clk. Start-bit edge at t+2.
- `start` pulsed again mid-dump with `word_count`=5 → ignored. Original 2-word dump completes unchanged.
- RESET during bit 4 of the third byte → `uart_tx`=1 within the same cycle, `busy`=0, no `done`. A subsequent start with `word_count`=1 produces a clean 6-byte dump.
- `word_count`=0x0100 → first bytes 00 01. 256 reads at indices 0..255. Measured inter-frame gaps ≤1 within a word and ≤3 across words.
